mem_req_gen: RTL and testbench

- Upstream stimulus sequencer for mem_ctrl.
- Accepts 4-bit memory requests via a valid/ready handshake and queues them in a small FIFO.
- Serialises each request into the beat protocol of the targeted channel (SDRAM 2-bit, flash 4-bit, ROM 1-bit).
- Three independent per-channel engines run concurrently; a broadcast target launches all three in the same cycle.

---
 rtl/mem_req_pkg.sv | 33 +++
 rtl/mem_req_gen_if.sv | 29 ++
 rtl/mem_req_fifo.sv | 55 +++++
 rtl/mem_req_gen.sv | 172 +++++++++++++++++
 tb/tb_mem_req_gen.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_req_pkg.sv
// Shared encodings for the memory request generator: targets, engine phases and
// per-channel beat counts.
package mem_req_pkg;

  localparam logic [1:0] TGT_SDRAM = 2'd0;
  localparam logic [1:0] TGT_FLASH = 2'd1;
  localparam logic [1:0] TGT_ROM   = 2'd2;
  localparam logic [1:0] TGT_ALL   = 2'd3;

  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_B0   = 3'd1,
    PH_B1   = 3'd2,
    PH_B2   = 3'd3,
    PH_B3   = 3'd4,
    PH_TERM = 3'd5,
    PH_GAP  = 3'd6
  } phase_e;

  localparam int unsigned SDRAM_BEATS = 3;
  localparam int unsigned FLASH_BEATS = 4;
  localparam int unsigned ROM_BEATS   = 4;

  // Beat phases are numbered from 1, so beat n-1 of an n-beat burst encodes as n.
  function automatic phase_e last_beat(input int unsigned beats);
    return phase_e'(3'(beats));
  endfunction

  function automatic phase_e next_ph(input phase_e ph);
    return phase_e'(ph + 3'd1);
  endfunction

endpackage

// File: rtl/mem_req_gen_if.sv
// Request handshake plus the three downstream beat channels of mem_req_gen.
interface mem_req_gen_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_target;
  logic [3:0] req_data;
  logic       sdram_ready;
  logic       flash_ready;
  logic       rom_ready;
  logic       sdram_valid;
  logic [1:0] sdram_data_o;
  logic       flash_valid;
  logic [3:0] flash_data_o;
  logic       rom_valid;
  logic       rom_data_o;
  logic [2:0] busy;

  modport slave (
    input  req_valid, req_target, req_data, sdram_ready, flash_ready, rom_ready,
    output req_ready, sdram_valid, sdram_data_o, flash_valid, flash_data_o,
           rom_valid, rom_data_o, busy
  );

  modport master (
    output req_valid, req_target, req_data, sdram_ready, flash_ready, rom_ready,
    input  req_ready, sdram_valid, sdram_data_o, flash_valid, flash_data_o,
           rom_valid, rom_data_o, busy
  );
endinterface

// File: rtl/mem_req_fifo.sv
// Synchronous FIFO with a registered occupancy count; full/empty are compares on
// that count, so a pop never frees a slot for a push in the same cycle.
module mem_req_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 6
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_head
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Storage array: contents need no reset, the pointers define validity.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr] <= i_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/mem_req_gen.sv
// Queues 4-bit requests and serialises them onto the SDRAM, flash and ROM beat
// channels with three concurrent engines. Define COV_MAP_EN for the phase-tuple coverage map.
module mem_req_gen
  import mem_req_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             meta_reset,
  mem_req_gen_if.slave     bus,
  output logic [CNT_W-1:0] done_count,
  output logic [8:0]       coverage
);
  logic       w_full, w_empty, w_pop;
  logic [5:0] w_head;
  logic [1:0] w_head_tgt;
  logic [3:0] w_head_data;
  logic [2:0] w_disp;
  logic [2:0] w_fin;

  phase_e     r_sd_ph, r_fl_ph, r_rom_ph;
  logic [1:0] r_sd_buf;
  logic [2:0] r_rom_buf;
  logic [CNT_W-1:0] r_done;

  mem_req_fifo #(.DEPTH(FIFO_DEPTH), .W(6)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (bus.req_valid),
    .i_data  ({bus.req_target, bus.req_data}),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  assign bus.req_ready = !w_full;
  assign w_head_tgt    = w_head[5:4];
  assign w_head_data   = w_head[3:0];
  assign w_pop         = |w_disp;

  // In-order dispatch: the head launches only when every engine it needs is free.
  always_comb begin
    w_disp = 3'b000;
    if (!w_empty && !reset) begin
      case (w_head_tgt)
        TGT_SDRAM: w_disp[0] = (r_sd_ph == PH_IDLE) && bus.sdram_ready;
        TGT_FLASH: w_disp[1] = (r_fl_ph == PH_IDLE) && bus.flash_ready;
        TGT_ROM:   w_disp[2] = (r_rom_ph == PH_IDLE) && bus.rom_ready;
        TGT_ALL:   w_disp = ((r_sd_ph == PH_IDLE) && bus.sdram_ready &&
                             (r_fl_ph == PH_IDLE) && bus.flash_ready &&
                             (r_rom_ph == PH_IDLE) && bus.rom_ready) ? 3'b111 : 3'b000;
        default:   w_disp = 3'b000;
      endcase
    end else begin
      w_disp = 3'b000;
    end
  end

  assign bus.busy = {r_rom_ph != PH_IDLE, r_fl_ph != PH_IDLE, r_sd_ph != PH_IDLE} | w_disp;
  assign w_fin    = {r_rom_ph == PH_GAP, r_fl_ph == PH_GAP, r_sd_ph == PH_GAP};

  // SDRAM engine: two data beats, an empty third beat, then TERM and GAP.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sd_ph <= PH_IDLE; bus.sdram_valid <= 1'b0; bus.sdram_data_o <= 2'd0; r_sd_buf <= 2'd0;
    end else begin
      bus.sdram_data_o <= 2'd0;
      bus.sdram_valid  <= 1'b0;
      case (r_sd_ph)
        PH_IDLE: if (w_disp[0]) begin
          r_sd_ph <= PH_B0; bus.sdram_valid <= 1'b1;
          bus.sdram_data_o <= w_head_data[1:0]; r_sd_buf <= w_head_data[3:2];
        end
        PH_B0:   begin r_sd_ph <= PH_B1; bus.sdram_valid <= 1'b1; bus.sdram_data_o <= r_sd_buf; end
        PH_B1:   begin r_sd_ph <= last_beat(SDRAM_BEATS); bus.sdram_valid <= 1'b1; end
        PH_B2:   r_sd_ph <= PH_TERM;
        PH_TERM: r_sd_ph <= PH_GAP;
        PH_GAP:  r_sd_ph <= PH_IDLE;
        default: r_sd_ph <= PH_IDLE;
      endcase
    end
  end

  // Flash engine: the whole nibble on beat 0, then three empty valid beats and GAP.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_fl_ph <= PH_IDLE; bus.flash_valid <= 1'b0; bus.flash_data_o <= 4'd0;
    end else begin
      bus.flash_data_o <= 4'd0;
      bus.flash_valid  <= 1'b0;
      case (r_fl_ph)
        PH_IDLE: if (w_disp[1]) begin
          r_fl_ph <= PH_B0; bus.flash_valid <= 1'b1; bus.flash_data_o <= w_head_data;
        end
        PH_B0, PH_B1, PH_B2, PH_B3: begin
          if (r_fl_ph == last_beat(FLASH_BEATS)) begin
            r_fl_ph <= PH_GAP;
          end else begin
            r_fl_ph <= next_ph(r_fl_ph); bus.flash_valid <= 1'b1;
          end
        end
        PH_GAP:  r_fl_ph <= PH_IDLE;
        default: r_fl_ph <= PH_IDLE;
      endcase
    end
  end

  // ROM engine: one payload bit per beat, LSB first, shifted out of a buffer.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rom_ph <= PH_IDLE; bus.rom_valid <= 1'b0; bus.rom_data_o <= 1'b0; r_rom_buf <= 3'd0;
    end else begin
      bus.rom_data_o <= 1'b0;
      bus.rom_valid  <= 1'b0;
      case (r_rom_ph)
        PH_IDLE: if (w_disp[2]) begin
          r_rom_ph <= PH_B0; bus.rom_valid <= 1'b1;
          bus.rom_data_o <= w_head_data[0]; r_rom_buf <= w_head_data[3:1];
        end
        PH_B0, PH_B1, PH_B2, PH_B3: begin
          if (r_rom_ph == last_beat(ROM_BEATS)) begin
            r_rom_ph <= PH_GAP;
          end else begin
            r_rom_ph <= next_ph(r_rom_ph); bus.rom_valid <= 1'b1;
            bus.rom_data_o <= r_rom_buf[0]; r_rom_buf <= {1'b0, r_rom_buf[2:1]};
          end
        end
        PH_GAP:  r_rom_ph <= PH_IDLE;
        default: r_rom_ph <= PH_IDLE;
      endcase
    end
  end

  // Completion counter: each engine leaving GAP adds one.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_done <= '0;
    end else begin
      r_done <= r_done + CNT_W'(w_fin[0]) + CNT_W'(w_fin[1]) + CNT_W'(w_fin[2]);
    end
  end

  assign done_count = r_done;

`ifdef COV_MAP_EN
  logic [511:0] r_map;
  logic [8:0]   r_cov;
  logic [8:0]   w_idx;

  assign w_idx    = {r_fl_ph, r_sd_ph, r_rom_ph};
  assign coverage = r_cov;

  // Coverage survives the functional reset; only meta_reset clears it.
  always_ff @(posedge clock) begin
    if (meta_reset) begin
      r_map <= '0;
      r_cov <= 9'd0;
    end else if (!r_map[w_idx]) begin
      r_map[w_idx] <= 1'b1;
      r_cov        <= r_cov + 9'd1;
    end
  end
`else
  logic w_unused_meta;
  assign w_unused_meta = meta_reset;
  assign coverage      = 9'd0;
`endif

endmodule

// File: tb/tb_mem_req_gen.sv
// Scoreboard bench for mem_req_gen: expected beats are queued per channel when a
// request is offered and popped as the DUT drives valid beats.
module tb_mem_req_gen;
  import mem_req_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       meta_reset;
  logic [7:0] done_count;
  logic [8:0] coverage;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [1:0] sd_q[$];
  logic [3:0] fl_q[$];
  logic       rom_q[$];
  logic [7:0] exp_done = 8'd0;

  mem_req_gen_if bus();

  mem_req_gen #(.FIFO_DEPTH(4), .CNT_W(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .meta_reset (meta_reset),
    .bus        (bus),
    .done_count (done_count),
    .coverage   (coverage)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void expect_req(input logic [1:0] tgt, input logic [3:0] d);
    if (tgt == TGT_SDRAM || tgt == TGT_ALL) begin
      sd_q.push_back(d[1:0]); sd_q.push_back(d[3:2]); sd_q.push_back(2'd0);
    end
    if (tgt == TGT_FLASH || tgt == TGT_ALL) begin
      fl_q.push_back(d); fl_q.push_back(4'd0); fl_q.push_back(4'd0); fl_q.push_back(4'd0);
    end
    if (tgt == TGT_ROM || tgt == TGT_ALL) begin
      for (int i = 0; i < 4; i++) rom_q.push_back(d[i]);
    end
  endfunction

  // Offer one request; returns #1 into the cycle after acceptance.
  task automatic send(input logic [1:0] tgt, input logic [3:0] d);
    int n = 0;
    @(posedge clock); #1;
    expect_req(tgt, d);
    bus.req_target = tgt; bus.req_data = d; bus.req_valid = 1'b1;
    @(negedge clock);
    while (!bus.req_ready && n < 200) begin @(negedge clock); n++; end
    if (n >= 200) check("send_timeout", 32'd1, 32'd0);
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
  endtask

  // Beat monitors: every valid beat must match the next expected beat of its channel.
  always @(negedge clock) begin
    if (bus.sdram_valid) begin
      if (sd_q.size() == 0) check("sd_extra_beat", 32'd1, 32'd0);
      else check("sd_data", 32'(bus.sdram_data_o), 32'(sd_q.pop_front()));
    end
    if (bus.flash_valid) begin
      if (fl_q.size() == 0) check("fl_extra_beat", 32'd1, 32'd0);
      else check("fl_data", 32'(bus.flash_data_o), 32'(fl_q.pop_front()));
    end
    if (bus.rom_valid) begin
      if (rom_q.size() == 0) check("rom_extra_beat", 32'd1, 32'd0);
      else check("rom_data", 32'(bus.rom_data_o), 32'(rom_q.pop_front()));
    end
  end

  initial begin
    int nb, nv, k, cyc;
    logic [7:0] d6;
    logic [4:0] pat;
    bit seen_full;

    bus.req_valid = 1'b0; bus.req_target = 2'd0; bus.req_data = 4'd0;
    bus.sdram_ready = 1'b1; bus.flash_ready = 1'b1; bus.rom_ready = 1'b1;
    reset = 1'b1; meta_reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_valids", 32'({bus.sdram_valid, bus.flash_valid, bus.rom_valid}), 32'd0);
    check("rst_data", 32'({bus.sdram_data_o, bus.flash_data_o, bus.rom_data_o}), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(done_count), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0; meta_reset = 1'b0;
    @(negedge clock);
    check("rst_ready", 32'(bus.req_ready), 32'd1);

    // SDRAM 0xB: dispatch at t+1, valid 1,1,1,0,0 from t+2, done at t+7.
    send(TGT_SDRAM, 4'hB);
    @(negedge clock);
    check("sd_disp_busy", 32'(bus.busy[0]), 32'd1);
    check("sd_disp_novalid", 32'(bus.sdram_valid), 32'd0);
    pat = 5'b11100;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("sd_valid_seq", 32'(bus.sdram_valid), 32'(pat[4-i]));
      check("sd_busy_seq", 32'(bus.busy[0]), 32'd1);
    end
    @(negedge clock);
    exp_done = exp_done + 8'd1;
    check("sd_done", 32'(done_count), 32'(exp_done));
    check("sd_idle", 32'(bus.busy[0]), 32'd0);

    // Flash 0x6: 4 valid beats, busy for 6 cycles.
    send(TGT_FLASH, 4'h6);
    nb = 0; nv = 0;
    repeat (10) begin
      @(negedge clock);
      nb += int'(bus.busy[1]); nv += int'(bus.flash_valid);
    end
    check("fl_busy_cycles", 32'(nb), 32'd6);
    check("fl_valid_cycles", 32'(nv), 32'd4);
    exp_done = exp_done + 8'd1;
    check("fl_done", 32'(done_count), 32'(exp_done));

    // ROM 0x5: bits 1,0,1,0 over 4 valid beats.
    send(TGT_ROM, 4'h5);
    nv = 0;
    repeat (10) begin @(negedge clock); nv += int'(bus.rom_valid); end
    check("rom_valid_cycles", 32'(nv), 32'd4);
    exp_done = exp_done + 8'd1;
    check("rom_done", 32'(done_count), 32'(exp_done));

    // Broadcast 0xF: all three GAP cycles coincide at t+6, done jumps by 3.
    send(TGT_ALL, 4'hF);
    @(negedge clock);
    check("bc_disp_busy", 32'(bus.busy), 32'd7);
    repeat (4) @(negedge clock);
    check("bc_t5_valids", 32'({bus.rom_valid, bus.flash_valid, bus.sdram_valid}), 32'b110);
    @(negedge clock);
    check("bc_gap_valids", 32'({bus.rom_valid, bus.flash_valid, bus.sdram_valid}), 32'd0);
    check("bc_gap_busy", 32'(bus.busy), 32'd7);
    d6 = done_count;
    @(negedge clock);
    exp_done = exp_done + 8'd3;
    check("bc_done_step", 32'(done_count), 32'(d6 + 8'd3));
    check("bc_done_total", 32'(done_count), 32'(exp_done));

    // Back-pressure: flash held not-ready so the FIFO fills, then released.
    @(posedge clock); #1;
    bus.flash_ready = 1'b0;
    bus.req_target = TGT_FLASH; bus.req_valid = 1'b1;
    k = 0; cyc = 0; seen_full = 1'b0;
    while (k < 5 && cyc < 100) begin
      bus.req_data = 4'(k + 1);
      @(negedge clock);
      if (bus.req_ready) begin
        expect_req(TGT_FLASH, 4'(k + 1));
        k++;
      end else if (!seen_full) begin
        seen_full = 1'b1;
        check("bp_full_after", 32'(k), 32'd4);
        bus.flash_ready = 1'b1;
      end
      @(posedge clock); #1;
      cyc++;
    end
    bus.req_valid = 1'b0;
    check("bp_saw_full", 32'(seen_full), 32'd1);
    check("bp_all_accepted", 32'(k), 32'd5);
    exp_done = exp_done + 8'd5;
    cyc = 0;
    while (done_count != exp_done && cyc < 200) begin @(negedge clock); cyc++; end
    check("bp_done", 32'(done_count), 32'(exp_done));

    // Reset during SDRAM B1 with a flash request still queued.
    send(TGT_SDRAM, 4'h9);
    bus.flash_ready = 1'b0;
    send(TGT_FLASH, 4'h3);
    reset = 1'b1;
    @(negedge clock);
    check("ab_b1_valid", 32'(bus.sdram_valid), 32'd1);
    @(posedge clock); #1;
    sd_q.delete(); fl_q.delete(); rom_q.delete();
    @(negedge clock);
    check("ab_valid_low", 32'({bus.sdram_valid, bus.flash_valid, bus.rom_valid}), 32'd0);
    check("ab_busy", 32'(bus.busy), 32'd0);
    check("ab_done", 32'(done_count), 32'd0);
    check("ab_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clock); #1;
    reset = 1'b0; bus.flash_ready = 1'b1;
    nv = 0;
    repeat (10) begin @(negedge clock); nv += int'(bus.flash_valid); end
    check("ab_fifo_flushed", 32'(nv), 32'd0);
    check("ab_done_after", 32'(done_count), 32'd0);

`ifdef COV_MAP_EN
    check("cov_kept", 32'(coverage != 9'd0), 32'd1);
    @(posedge clock); #1;
    meta_reset = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    check("cov_cleared", 32'(coverage), 32'd0);
    meta_reset = 1'b0;
`else
    check("cov_off", 32'(coverage), 32'd0);
`endif

    check("sd_q_empty", 32'(sd_q.size()), 32'd0);
    check("fl_q_empty", 32'(fl_q.size()), 32'd0);
    check("rom_q_empty", 32'(rom_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
